// File: rtl/ifu_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_prefetch_pkg
// Shared constants and types for the instruction prefetch unit.
//   DATA_BUS_WIDTH / RESET_PC_ADDR / INST_BYTES come from the project-wide
//   parameter defines; defaults below apply when they are not already set.
//   Optional feature macro used by the IFU: IFU_PERF_CNT_EN (perf counters).
// ---------------------------------------------------------------------------
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif
`ifndef RESET_PC_ADDR
`define RESET_PC_ADDR 32'h0000_0000
`endif
`ifndef INST_BYTES
`define INST_BYTES 4
`endif

package ifu_prefetch_pkg;

    localparam int unsigned IfuDataW     = `DATA_BUS_WIDTH;
    localparam logic [IfuDataW-1:0] IfuResetPc = `RESET_PC_ADDR;
    localparam int unsigned IfuInstBytes = `INST_BYTES;

    // Source of a flush in the current cycle; reset outranks jump.
    typedef enum logic [1:0] {
        FlushNone,
        FlushJump,
        FlushReset
    } ifu_flush_e;

    // Pointer width for a power-of-two buffer of the given depth.
    function automatic int unsigned ifu_ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo
// Synchronous prefetch FIFO with registered storage (no bypass path).
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   i_clear          drop all entries (wins over push/pop)
//   i_push, i_data   write one entry
//   i_pop            remove head entry
//   o_data           head entry
//   o_count          current occupancy
//   o_empty, o_full  occupancy flags
// ---------------------------------------------------------------------------
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_full
);

    localparam int unsigned AW = ifu_ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_pop   = i_pop & ~o_empty;
    // A simultaneous pop frees the slot, so push is accepted even when full.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Writing a full FIFO without a pop would lose data.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
                     (i_push && !i_clear && o_full) |-> i_pop);

endmodule

// File: rtl/ifu_prefetch.sv
// ---------------------------------------------------------------------------
// ifu_prefetch
// Instruction fetch unit: PC generator, req/gnt/rvalid bus engine and a
// prefetch FIFO feeding decode through a valid/ready handshake.
// Optional feature: define IFU_PERF_CNT_EN to add perf_fetch_cnt_o and
// perf_flush_cnt_o.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   reset_flag_i       software reset: flush and restart at RESET_PC
//   jump_flag_i        redirect: flush and restart at jump_addr_i (word aligned)
//   jump_addr_i        redirect target
//   ibus_req_o         fetch request
//   ibus_addr_o        fetch address (word aligned)
//   ibus_gnt_i         request accepted when req & gnt
//   ibus_rvalid_i      in-order response valid
//   ibus_rdata_i       response instruction word
//   inst_valid_o       head of prefetch FIFO valid
//   inst_ready_i       decode accepts head
//   inst_o, inst_pc_o  head instruction and its PC
//   perf_fetch_cnt_o   (IFU_PERF_CNT_EN) instructions handed to decode
//   perf_flush_cnt_o   (IFU_PERF_CNT_EN) flush cycles
// ---------------------------------------------------------------------------
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned       DATA_W     = IfuDataW,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       MAX_OUTST  = 2,
    parameter logic [DATA_W-1:0] RESET_PC   = DATA_W'(`RESET_PC_ADDR)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              reset_flag_i,
    input  logic              jump_flag_i,
    input  logic [DATA_W-1:0] jump_addr_i,
    output logic              ibus_req_o,
    output logic [DATA_W-1:0] ibus_addr_o,
    input  logic              ibus_gnt_i,
    input  logic              ibus_rvalid_i,
    input  logic [DATA_W-1:0] ibus_rdata_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [DATA_W-1:0] inst_pc_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_flush_cnt_o
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_W-1:0] PcStep = DATA_W'(IfuInstBytes);

    logic [DATA_W-1:0]   r_fetch_pc;
    logic [DATA_W-1:0]   r_resp_pc;
    // r_outst counts every request in flight, including ones marked for discard.
    logic [OW-1:0]       r_outst;
    logic [OW-1:0]       r_discard;

    ifu_flush_e          w_cause;
    logic                w_flush;
    logic [DATA_W-1:0]   w_target;
    logic                w_room;
    logic                w_req;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic                w_inst_valid;
    logic [OW-1:0]       w_outst_d;
    logic [OW-1:0]       w_discard_d;
    logic [CW-1:0]       w_fifo_cnt;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [2*DATA_W-1:0] w_head;

    // Flush source and restart target.
    always_comb begin
        w_cause = FlushNone;
        if (reset_flag_i) begin
            w_cause = FlushReset;
        end else if (jump_flag_i) begin
            w_cause = FlushJump;
        end
    end

    assign w_flush = (w_cause != FlushNone);

    always_comb begin
        w_target = RESET_PC;
        case (w_cause)
            FlushJump: w_target = {jump_addr_i[DATA_W-1:2], 2'b00};
            default:   w_target = RESET_PC;
        endcase
    end

    // Credit: never have more requests in flight than the FIFO can absorb.
    assign w_room  = (32'(r_outst) < MAX_OUTST) &&
                     ((32'(w_fifo_cnt) + 32'(r_outst)) < FIFO_DEPTH);
    // Gated with reset so the bus sees no request while reset is asserted.
    assign w_req   = rst_n_i & ~w_flush & w_room;
    assign w_grant = w_req & ibus_gnt_i;

    assign w_push       = ibus_rvalid_i & ~w_flush & (r_discard == '0);
    assign w_inst_valid = ~w_fifo_empty & ~w_flush;
    assign w_pop        = w_inst_valid & inst_ready_i;

    assign w_outst_d = r_outst + OW'(w_grant) - OW'(ibus_rvalid_i);

    // On flush every request still in flight after this cycle becomes stale.
    // r_outst already includes earlier stale requests, so the count is
    // recomputed rather than accumulated; back-to-back flushes stay exact.
    always_comb begin
        w_discard_d = r_discard;
        if (w_flush) begin
            w_discard_d = r_outst - OW'(ibus_rvalid_i);
        end else if (ibus_rvalid_i && (r_discard != '0)) begin
            w_discard_d = r_discard - OW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst   <= w_outst_d;
            r_discard <= w_discard_d;
            if (w_flush) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + PcStep;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PcStep;
                end
            end
        end
    end

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .i_clear (w_flush),
        .i_push  (w_push),
        .i_data  ({r_resp_pc, ibus_rdata_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_cnt),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign ibus_req_o   = w_req;
    assign ibus_addr_o  = r_fetch_pc;
    assign inst_valid_o = w_inst_valid;
    assign inst_pc_o    = w_head[2*DATA_W-1:DATA_W];
    assign inst_o       = w_head[DATA_W-1:0];

    // A response with nothing in flight means the bus broke ordering.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
                     ibus_rvalid_i |-> (r_outst != '0));
    // Credit logic guarantees a slot for every accepted response.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
                     (w_push && w_fifo_full) |-> w_pop);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_fetch_cnt;
    logic [31:0] r_perf_flush_cnt;

    // Only hardware reset clears these; software reset is itself a flush.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_perf_fetch_cnt <= '0;
            r_perf_flush_cnt <= '0;
        end else begin
            if (w_pop) begin
                r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
            end
            if (w_flush) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = r_perf_fetch_cnt;
    assign perf_flush_cnt_o = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
`timescale 1ns/1ps
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
    localparam logic [31:0] RPC = IfuResetPc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reset_flag = 1'b0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_addr = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        valid;
    logic        ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    always #5 clk = ~clk;

    ifu_prefetch #(
        .DATA_W     (32),
        .FIFO_DEPTH (DEPTH),
        .MAX_OUTST  (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .reset_flag_i  (reset_flag),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .ibus_req_o    (req),
        .ibus_addr_o   (addr),
        .ibus_gnt_i    (gnt),
        .ibus_rvalid_i (rvalid),
        .ibus_rdata_i  (rdata),
        .inst_valid_o  (valid),
        .inst_ready_i  (ready),
        .inst_o        (inst),
        .inst_pc_o     (pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o (perf_fetch),
        .perf_flush_cnt_o (perf_flush)
`endif
    );

    // Reference model: program order of words and which in-flight fetches are stale.
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] a; int g; } pend_t;

    logic [31:0] m_fetch_pc, m_resp_pc;
    bit          m_bus[$];      // one flag per in-flight fetch: 1 = stale
    ent_t        m_fifo[$];
    int          m_pops, m_flushes;

    pend_t       pend[$];       // bus environment: granted requests awaiting a response
    int          cyc = 0;
    int          lat = 1;
    bit          rv_en = 1'b1;
    int          rel_cyc = 0;

    logic [31:0] obs_pcs[$];
    logic [31:0] obs_insts[$];
    logic [31:0] obs_cycs[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_fetch_pc = RPC;
        m_resp_pc  = RPC;
        m_bus.delete();
        m_fifo.delete();
        pend.delete();
        m_pops = 0;
        m_flushes = 0;
    endtask

    task automatic clear_obs();
        obs_pcs.delete();
        obs_insts.delete();
        obs_cycs.delete();
    endtask

    // One clock cycle: compare at negedge, advance model, then drive the bus response.
    task automatic step();
        bit          flush, e_req, e_valid, stale;
        logic [31:0] tgt;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_req", 32'(req), 32'd0);
            check("rst_addr", addr, RPC);
            check("rst_valid", 32'(valid), 32'd0);
            check("rst_inst", inst, 32'd0);
            check("rst_pc", pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
            check("rst_perf_fetch", perf_fetch, 32'd0);
            check("rst_perf_flush", perf_flush, 32'd0);
`endif
        end else begin
            flush   = reset_flag | jump_flag;
            e_req   = !flush && (m_bus.size() < MAXO) && (m_fifo.size() + m_bus.size() < DEPTH);
            e_valid = !flush && (m_fifo.size() != 0);
            check("req", 32'(req), 32'(e_req));
            check("addr", addr, m_fetch_pc);
            check("valid", 32'(valid), 32'(e_valid));
            if (e_valid) begin
                check("inst", inst, m_fifo[0].inst);
                check("inst_pc", pc, m_fifo[0].pc);
            end
`ifdef IFU_PERF_CNT_EN
            check("perf_fetch", perf_fetch, 32'(m_pops));
            check("perf_flush", perf_flush, 32'(m_flushes));
`endif
            if (valid && ready) begin
                obs_pcs.push_back(pc);
                obs_insts.push_back(inst);
                obs_cycs.push_back(32'(cyc));
            end
            if (req && gnt) pend.push_back('{a: addr, g: cyc});

            if (e_valid && ready) begin
                void'(m_fifo.pop_front());
                m_pops++;
            end
            if (rvalid) begin
                check("rvalid_in_flight", 32'(m_bus.size() != 0), 32'd1);
                if (m_bus.size() != 0) begin
                    stale = m_bus.pop_front();
                    if (!stale && !flush) begin
                        m_fifo.push_back('{pc: m_resp_pc, inst: rdata});
                        m_resp_pc += 32'd4;
                    end
                end
            end
            if (flush) begin
                m_flushes++;
                m_fifo.delete();
                foreach (m_bus[i]) m_bus[i] = 1'b1;
                tgt = reset_flag ? RPC : {jump_addr[31:2], 2'b00};
                m_fetch_pc = tgt;
                m_resp_pc  = tgt;
            end else if (e_req && gnt) begin
                m_bus.push_back(1'b0);
                m_fetch_pc += 32'd4;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (rst_n && rv_en && pend.size() != 0 && cyc >= pend[0].g + lat) begin
            rvalid = 1'b1;
            rdata  = mem_word(pend[0].a);
            void'(pend.pop_front());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gnt = 1'b0;
        ready = 1'b0;
        reset_flag = 1'b0;
        jump_flag = 1'b0;
        rvalid = 1'b0;
        rv_en = 1'b1;
        lat = 1;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        int          n;
        int          stale_cnt;
        logic [31:0] t1_last;

        // 1: streaming from reset
        do_reset();
        gnt = 1'b1;
        ready = 1'b1;
        clear_obs();
        run(10);
        check("t1_first_latency", qget(obs_cycs, 0) - 32'(rel_cyc), 32'd2);
        check("t1_pc0", qget(obs_pcs, 0), 32'h0000_0000);
        check("t1_pc1", qget(obs_pcs, 1), 32'h0000_0004);
        check("t1_pc2", qget(obs_pcs, 2), 32'h0000_0008);
        check("t1_inst0", qget(obs_insts, 0), mem_word(32'h0));
        check("t1_back_to_back1", qget(obs_cycs, 1) - qget(obs_cycs, 0), 32'd1);
        check("t1_back_to_back2", qget(obs_cycs, 2) - qget(obs_cycs, 1), 32'd1);
        t1_last = qget(obs_pcs, obs_pcs.size() - 1);

        // 2: decode stalls, FIFO fills, request drops, then drains in order
        ready = 1'b0;
        run(10);
        check("t2_buffered", 32'(m_fifo.size()), 32'd4);
        check("t2_req_low", 32'(req), 32'd0);
        check("t2_valid_high", 32'(valid), 32'd1);
        ready = 1'b1;
        clear_obs();
        run(8);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_pc", qget(obs_pcs, i), t1_last + 32'(4 * (i + 1)));
            check("t2_drain_cycle", qget(obs_cycs, i) - qget(obs_cycs, 0), 32'(i));
        end

        // 3: jump with two fetches in flight
        rv_en = 1'b0;
        n = 0;
        while (m_bus.size() != 2 && n < 10) begin
            step();
            n++;
        end
        check("t3_two_outstanding", 32'(m_bus.size()), 32'd2);
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0103;
        clear_obs();
        step();
        jump_flag = 1'b0;
        rv_en = 1'b1;
        stale_cnt = 0;
        foreach (m_bus[i]) stale_cnt += int'(m_bus[i]);
        check("t3_stale_count", 32'(stale_cnt), 32'd2);
        check("t3_addr_after_jump", addr, 32'h0000_0100);
        run(10);
        check("t3_first_pc", qget(obs_pcs, 0), 32'h0000_0100);
        check("t3_first_inst", qget(obs_insts, 0), mem_word(32'h0000_0100));
        check("t3_second_pc", qget(obs_pcs, 1), 32'h0000_0104);

        // 4: reset_flag outranks jump_flag
        reset_flag = 1'b1;
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0200;
        clear_obs();
        step();
        reset_flag = 1'b0;
        jump_flag = 1'b0;
        check("t4_addr_restart", addr, RPC);
        run(10);
        check("t4_first_pc", qget(obs_pcs, 0), RPC);

        // 5: fetch address wraps at the top of the address space
        gnt = 1'b0;
        run(4);
        jump_flag = 1'b1;
        jump_addr = 32'hFFFF_FFFE;
        clear_obs();
        step();
        jump_flag = 1'b0;
        check("t5_addr_top", addr, 32'hFFFF_FFFC);
        gnt = 1'b1;
        step();
        check("t5_addr_wrap", addr, 32'h0000_0000);
        run(8);
        check("t5_pc_top", qget(obs_pcs, 0), 32'hFFFF_FFFC);
        check("t5_pc_wrap", qget(obs_pcs, 1), 32'h0000_0000);

        // Mixed traffic: random grant, ready, latency and redirects
        for (int i = 0; i < 300; i++) begin
            gnt        = ($urandom_range(3) != 0);
            ready      = ($urandom_range(2) != 0);
            lat        = int'($urandom_range(3, 1));
            jump_flag  = ($urandom_range(24) == 0);
            reset_flag = ($urandom_range(59) == 0);
            jump_addr  = $urandom;
            step();
        end
        jump_flag = 1'b0;
        reset_flag = 1'b0;

`ifdef IFU_PERF_CNT_EN
        // 6: seven pops and two flushes from hardware reset
        do_reset();
        gnt = 1'b1;
        n = 0;
        while (m_pops < 7 && n < 40) begin
            ready = (m_pops < 7);
            step();
            n++;
        end
        ready = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0040;
        step();
        jump_flag = 1'b0;
        step();
        reset_flag = 1'b1;
        step();
        reset_flag = 1'b0;
        run(2);
        check("t6_perf_fetch", perf_fetch, 32'd7);
        check("t6_perf_flush", perf_flush, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
